// File: rtl/rc_reset_sequencer.sv
// Reset sequencer for the Rocket host-clock domain: releases core reset after MMCM lock and MIG
// calibration, watches for their loss, and runs drained warm resets on software request.
module rc_reset_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned CALIB_TIMEOUT = 1048576,
  parameter int unsigned DRAIN_TIMEOUT = 4096,
  parameter int unsigned OUTSTANDING_W = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mmcm_locked,
  input  logic                     ddr_calib_done,
  input  logic                     sw_reset_req,
  input  logic                     sw_retry,
  input  logic                     mem_ar_valid,
  input  logic                     mem_ar_ready,
  input  logic                     mem_aw_valid,
  input  logic                     mem_aw_ready,
  input  logic                     mem_r_valid,
  input  logic                     mem_r_ready,
  input  logic                     mem_r_last,
  input  logic                     mem_b_valid,
  input  logic                     mem_b_ready,
  output logic                     core_reset,
  output logic                     mem_req_block,
  output logic [2:0]               state,
  output logic [OUTSTANDING_W-1:0] outstanding_rd,
  output logic [OUTSTANDING_W-1:0] outstanding_wr,
  output logic [7:0]               lock_loss_count,
  output logic                     fault,
  output logic                     drain_forced
);

  localparam int unsigned TimerMax0 =
      (CALIB_TIMEOUT > HOLD_CYCLES) ? CALIB_TIMEOUT : HOLD_CYCLES;
  localparam int unsigned TimerMax  = (TimerMax0 > DRAIN_TIMEOUT) ? TimerMax0 : DRAIN_TIMEOUT;
  localparam int unsigned TimerW    = $clog2(TimerMax + 1);

  localparam logic [TimerW-1:0] HoldLast  = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] CalibLast = TimerW'(CALIB_TIMEOUT - 1);
  localparam logic [TimerW-1:0] DrainLast = TimerW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StWaitCalib = 3'd1,
    StHold      = 3'd2,
    StRun       = 3'd3,
    StDrain     = 3'd4,
    StFault     = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [TimerW-1:0]        timer_q, timer_d;
  logic [SYNC_STAGES-1:0]   lock_sync_q, calib_sync_q;
  logic                     lock_s, calib_s;
  logic                     core_reset_q, core_reset_d;
  logic                     block_q, block_d;
  logic                     fault_q, fault_d;
  logic                     forced_q, forced_d;
  logic [OUTSTANDING_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [7:0]               llc_q, llc_d;
  logic                     lock_lost, drain_timed_out;
  logic                     rd_inc, rd_dec, wr_inc, wr_dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q  <= '0;
      calib_sync_q <= '0;
    end else begin
      lock_sync_q[0]  <= mmcm_locked;
      calib_sync_q[0] <= ddr_calib_done;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        lock_sync_q[i]  <= lock_sync_q[i-1];
        calib_sync_q[i] <= calib_sync_q[i-1];
      end
    end
  end

  assign lock_s  = lock_sync_q[SYNC_STAGES-1];
  assign calib_s = calib_sync_q[SYNC_STAGES-1];

  // State register together with every registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StWaitLock;
      timer_q      <= '0;
      core_reset_q <= 1'b1;
      block_q      <= 1'b1;
      fault_q      <= 1'b0;
      forced_q     <= 1'b0;
      rd_q         <= '0;
      wr_q         <= '0;
      llc_q        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      core_reset_q <= core_reset_d;
      block_q      <= block_d;
      fault_q      <= fault_d;
      forced_q     <= forced_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      llc_q        <= llc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    lock_lost       = 1'b0;
    drain_timed_out = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s) state_d = StWaitCalib;
      end
      StWaitCalib: begin
        if (!lock_s)                  state_d = StWaitLock;
        else if (timer_q == CalibLast) state_d = StFault;
        else if (calib_s)             state_d = StHold;
      end
      StHold: begin
        if (!lock_s)                 state_d = StWaitLock;
        else if (!calib_s)           state_d = StWaitCalib;
        else if (timer_q == HoldLast) state_d = StRun;
      end
      StRun: begin
        if (!lock_s) begin
          state_d   = StWaitLock;
          lock_lost = 1'b1;
        end else if (!calib_s) begin
          state_d = StWaitCalib;
        end else if (sw_reset_req) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!lock_s) begin
          state_d   = StWaitLock;
          lock_lost = 1'b1;
        end else if (!calib_s) begin
          state_d = StWaitCalib;
        end else if (rd_q == '0 && wr_q == '0) begin
          state_d = StHold;
        end else if (timer_q == DrainLast) begin
          state_d         = StHold;
          drain_timed_out = 1'b1;
        end
      end
      StFault: begin
        if (sw_retry) state_d = StWaitLock;
      end
      default: state_d = StWaitLock;
    endcase
  end

  always_comb begin
    core_reset_d = 1'b1;
    block_d      = 1'b1;
    fault_d      = 1'b0;
    unique case (state_d)
      StRun: begin
        core_reset_d = 1'b0;
        block_d      = 1'b0;
      end
      StDrain: core_reset_d = 1'b0;
      StFault: fault_d      = 1'b1;
      default: ;
    endcase
  end

  function automatic logic [OUTSTANDING_W-1:0] step_count(
    input logic [OUTSTANDING_W-1:0] cnt,
    input logic                     inc,
    input logic                     dec
  );
    logic [OUTSTANDING_W-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != '1)      res = cnt + OUTSTANDING_W'(1);
    else if (dec && !inc && cnt != '0) res = cnt - OUTSTANDING_W'(1);
    return res;
  endfunction

  assign rd_inc = mem_ar_valid & mem_ar_ready;
  assign rd_dec = mem_r_valid & mem_r_ready & mem_r_last;
  assign wr_inc = mem_aw_valid & mem_aw_ready;
  assign wr_dec = mem_b_valid & mem_b_ready;

  // Counters clear in step with core_reset so they read zero whenever the core is held.
  always_comb begin
    rd_d     = core_reset_d ? '0 : step_count(rd_q, rd_inc, rd_dec);
    wr_d     = core_reset_d ? '0 : step_count(wr_q, wr_inc, wr_dec);
    llc_d    = (lock_lost && llc_q != 8'hFF) ? llc_q + 8'd1 : llc_q;
    forced_d = forced_q | drain_timed_out;
    timer_d  = (state_d != state_q) ? '0 : timer_q + TimerW'(1);
  end

  assign state           = state_q;
  assign core_reset      = core_reset_q;
  assign mem_req_block   = block_q;
  assign fault           = fault_q;
  assign drain_forced    = forced_q;
  assign outstanding_rd  = rd_q;
  assign outstanding_wr  = wr_q;
  assign lock_loss_count = llc_q;

endmodule
